// File: rtl/gate_checker_pkg.sv
// Shared types and the golden gate function for the primitive-gate self-test engine.
package gate_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } chk_state_t;

  localparam int MASK_AND  = 0;
  localparam int MASK_OR   = 1;
  localparam int MASK_NOR  = 2;
  localparam int MASK_NAND = 3;
  localparam int MASK_XOR  = 4;
  localparam int MASK_NOT  = 5;
  localparam int MASK_XNOR = 6;

  function automatic logic [6:0] gate_expect(input logic a, input logic b);
    logic [6:0] e;
    e            = '0;
    e[MASK_AND]  = a & b;
    e[MASK_OR]   = a | b;
    e[MASK_NOR]  = ~(a | b);
    e[MASK_NAND] = ~(a & b);
    e[MASK_XOR]  = a ^ b;
    e[MASK_NOT]  = ~a;
    e[MASK_XNOR] = ~(a ^ b);
    return e;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the seven gate outputs; also reused by the des scoreboard.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output logic [6:0] expected
);

  assign expected = gate_expect(a, b);

endmodule

// File: rtl/gate_checker.sv
// Stimulus/response engine: sweeps {b,a} through all four vectors, checks des outputs
// after a settle window, and reports mismatch count plus the first failing vector.
module gate_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             y_and,
  input  logic             y_or,
  input  logic             y_nor,
  input  logic             y_nand,
  input  logic             y_xor,
  input  logic             y_not,
  input  logic             y_xnor,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic [6:0]       first_fail_mask
);

  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  chk_state_t     state;
  logic [1:0]     vec;
  logic [PW-1:0]  pass_cnt;
  logic [SW-1:0]  settle_cnt;
  logic [6:0]     expected;
  logic [6:0]     actual;
  logic [6:0]     mask;
  logic [ERR_W-1:0] err_inc;
  logic           last_vec;

  gate_ref_model u_ref (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  assign actual   = {y_xnor, y_not, y_xor, y_nand, y_nor, y_or, y_and};
  assign mask     = actual ^ expected;
  assign err_inc  = (err_count == '1) ? err_count : err_count + ERR_W'(1);
  assign last_vec = (vec == 2'd3) && (pass_cnt == PW'(NUM_PASSES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      a               <= 1'b0;
      b               <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
      vec             <= '0;
      pass_cnt        <= '0;
      settle_cnt      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= DRIVE;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
            vec             <= '0;
            pass_cnt        <= '0;
          end
        end
        DRIVE: begin
          a          <= vec[0];
          b          <= vec[1];
          settle_cnt <= SW'(SETTLE_CYCLES - 1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= CHECK;
          else settle_cnt <= settle_cnt - SW'(1);
        end
        CHECK: begin
          if (mask != '0) begin
            err_count <= err_inc;
            if (err_count == '0) begin
              first_fail_vec  <= {b, a};
              first_fail_mask <= mask;
            end
          end
          if (last_vec) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // Fold in this final vector's result, since err_count updates on the same edge.
            pass  <= (mask == '0) && (err_count == '0);
          end else begin
            vec   <= vec + 2'd1;
            if (vec == 2'd3) pass_cnt <= pass_cnt + PW'(1);
            state <= DRIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_checker.sv
// Directed bench for gate_checker: five instances (default, 3 passes, 3-bit counter,
// settle 1, settle 5) each driven by a behavioural des with injectable faults.
module tb_gate_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start [5];
  logic [6:0] flip  [5];
  logic [6:0] stk1  [5];
  logic [6:0] stk0  [5];
  logic [6:0] gold  [5];
  logic [6:0] y     [5];
  logic       a_s [5], b_s [5], busy_s [5], done_s [5], pass_s [5];
  logic [7:0] err_s [5];
  logic [2:0] err3;
  logic [1:0] ffv [5];
  logic [6:0] ffm [5];

  int n_pass = 0;
  int n_total = 0;

  for (genvar i = 0; i < 5; i++) begin : g_des
    assign gold[i] = {~(a_s[i] ^ b_s[i]), ~a_s[i], a_s[i] ^ b_s[i], ~(a_s[i] & b_s[i]),
                      ~(a_s[i] | b_s[i]), a_s[i] | b_s[i], a_s[i] & b_s[i]};
    assign y[i] = ((gold[i] ^ flip[i]) | stk1[i]) & ~stk0[i];
  end

  assign err_s[2] = {5'd0, err3};

  gate_checker u_def (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a_s[0]), .b(b_s[0]),
    .y_and(y[0][0]), .y_or(y[0][1]), .y_nor(y[0][2]), .y_nand(y[0][3]),
    .y_xor(y[0][4]), .y_not(y[0][5]), .y_xnor(y[0][6]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err_s[0]),
    .first_fail_vec(ffv[0]), .first_fail_mask(ffm[0]));

  gate_checker #(.NUM_PASSES(3)) u_np3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a_s[1]), .b(b_s[1]),
    .y_and(y[1][0]), .y_or(y[1][1]), .y_nor(y[1][2]), .y_nand(y[1][3]),
    .y_xor(y[1][4]), .y_not(y[1][5]), .y_xnor(y[1][6]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err_s[1]),
    .first_fail_vec(ffv[1]), .first_fail_mask(ffm[1]));

  gate_checker #(.NUM_PASSES(3), .ERR_W(3)) u_e3 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .a(a_s[2]), .b(b_s[2]),
    .y_and(y[2][0]), .y_or(y[2][1]), .y_nor(y[2][2]), .y_nand(y[2][3]),
    .y_xor(y[2][4]), .y_not(y[2][5]), .y_xnor(y[2][6]),
    .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .err_count(err3),
    .first_fail_vec(ffv[2]), .first_fail_mask(ffm[2]));

  gate_checker #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .a(a_s[3]), .b(b_s[3]),
    .y_and(y[3][0]), .y_or(y[3][1]), .y_nor(y[3][2]), .y_nand(y[3][3]),
    .y_xor(y[3][4]), .y_not(y[3][5]), .y_xnor(y[3][6]),
    .busy(busy_s[3]), .done(done_s[3]), .pass(pass_s[3]), .err_count(err_s[3]),
    .first_fail_vec(ffv[3]), .first_fail_mask(ffm[3]));

  gate_checker #(.SETTLE_CYCLES(5)) u_s5 (
    .clk(clk), .rst_n(rst_n), .start(start[4]), .a(a_s[4]), .b(b_s[4]),
    .y_and(y[4][0]), .y_or(y[4][1]), .y_nor(y[4][2]), .y_nand(y[4][3]),
    .y_xor(y[4][4]), .y_not(y[4][5]), .y_xnor(y[4][6]),
    .busy(busy_s[4]), .done(done_s[4]), .pass(pass_s[4]), .err_count(err_s[4]),
    .first_fail_vec(ffv[4]), .first_fail_mask(ffm[4]));

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input int i);
    start[i] = 1'b1;
    edges(1);
    start[i] = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if ({a_s[i], b_s[i], busy_s[i], done_s[i], pass_s[i]} !== 5'b0)
        $display("FAIL reset_ctl[%0d]: got %b want 00000", i,
                 {a_s[i], b_s[i], busy_s[i], done_s[i], pass_s[i]});
      else n_pass++;
      n_total++;
      if ({err_s[i], ffv[i], ffm[i]} !== 17'b0)
        $display("FAIL reset_regs[%0d]: got %h want 0", i, {err_s[i], ffv[i], ffm[i]});
      else n_pass++;
    end
  endtask

  task automatic test_clean_run();
    start_pulse(0);
    n_total++;
    if (busy_s[0] !== 1'b1) $display("FAIL t1_busy: got %b want 1", busy_s[0]);
    else n_pass++;
    edges(2);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if ({b_s[0], a_s[0]} !== 2'(k))
        $display("FAIL t1_vec%0d: got %b want %b", k, {b_s[0], a_s[0]}, 2'(k));
      else n_pass++;
      if (k < 3) edges(4);
    end
    edges(1);
    n_total++;
    if (done_s[0] !== 1'b0) $display("FAIL t1_done_early: got %b want 0", done_s[0]);
    else n_pass++;
    edges(1);
    n_total++;
    if ({done_s[0], busy_s[0], pass_s[0]} !== 3'b101)
      $display("FAIL t1_done16: got dbp=%b want 101", {done_s[0], busy_s[0], pass_s[0]});
    else n_pass++;
    n_total++;
    if (err_s[0] !== 8'd0) $display("FAIL t1_err: got %0d want 0", err_s[0]);
    else n_pass++;
  endtask

  task automatic test_xor_fault();
    stk0[0] = 7'b0010000;
    start_pulse(0);
    edges(16);
    n_total++;
    if ({done_s[0], pass_s[0]} !== 2'b10)
      $display("FAIL t2_done_pass: got %b want 10", {done_s[0], pass_s[0]});
    else n_pass++;
    n_total++;
    if (err_s[0] !== 8'd2) $display("FAIL t2_err: got %0d want 2", err_s[0]);
    else n_pass++;
    n_total++;
    if (ffv[0] !== 2'b01) $display("FAIL t2_ffv: got %b want 01", ffv[0]);
    else n_pass++;
    n_total++;
    if (ffm[0] !== 7'b0010000) $display("FAIL t2_ffm: got %b want 0010000", ffm[0]);
    else n_pass++;
    stk0[0] = 7'b0;
  endtask

  task automatic test_passes_saturation();
    stk1[1] = 7'b0000001;
    start_pulse(1);
    edges(47);
    n_total++;
    if (done_s[1] !== 1'b0) $display("FAIL t3_done_early: got %b want 0", done_s[1]);
    else n_pass++;
    edges(1);
    n_total++;
    if ({done_s[1], pass_s[1]} !== 2'b10)
      $display("FAIL t3_done_pass: got %b want 10", {done_s[1], pass_s[1]});
    else n_pass++;
    n_total++;
    if (err_s[1] !== 8'd9) $display("FAIL t3_err: got %0d want 9", err_s[1]);
    else n_pass++;
    n_total++;
    if ({ffv[1], ffm[1]} !== {2'b00, 7'b0000001})
      $display("FAIL t3_first: got vec=%b mask=%b want 00/0000001", ffv[1], ffm[1]);
    else n_pass++;
    flip[2] = 7'b0100000;
    start_pulse(2);
    edges(48);
    n_total++;
    if (err_s[2] !== 8'd7) $display("FAIL t3_sat: got %0d want 7", err_s[2]);
    else n_pass++;
    n_total++;
    if ({done_s[2], pass_s[2]} !== 2'b10)
      $display("FAIL t3_sat_pass: got %b want 10", {done_s[2], pass_s[2]});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    // u_def is in DONE with err_count=2 from the xor fault; a new start must clear it.
    start_pulse(0);
    n_total++;
    if ({done_s[0], busy_s[0], pass_s[0]} !== 3'b010)
      $display("FAIL t4_restart_ctl: got dbp=%b want 010", {done_s[0], busy_s[0], pass_s[0]});
    else n_pass++;
    n_total++;
    if ({err_s[0], ffv[0], ffm[0]} !== 17'b0)
      $display("FAIL t4_restart_clr: got %h want 0", {err_s[0], ffv[0], ffm[0]});
    else n_pass++;
    for (int c = 1; c <= 16; c++) begin
      start[0] = (c == 4) || (c == 9) || (c == 10);
      edges(1);
      if (c == 15) begin
        n_total++;
        if ({done_s[0], busy_s[0]} !== 2'b01)
          $display("FAIL t4_busy15: got db=%b want 01", {done_s[0], busy_s[0]});
        else n_pass++;
      end
    end
    start[0] = 1'b0;
    n_total++;
    if ({done_s[0], busy_s[0], pass_s[0]} !== 3'b101)
      $display("FAIL t4_done16: got dbp=%b want 101", {done_s[0], busy_s[0], pass_s[0]});
    else n_pass++;
    edges(3);
    n_total++;
    if ({done_s[0], busy_s[0], b_s[0], a_s[0]} !== 4'b1011)
      $display("FAIL t4_hold: got db,ba=%b want 1011", {done_s[0], busy_s[0], b_s[0], a_s[0]});
    else n_pass++;
  endtask

  task automatic test_async_reset();
    stk0[0] = 7'b0010000;
    start_pulse(0);
    edges(6);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({a_s[0], b_s[0], busy_s[0], done_s[0], pass_s[0]} !== 5'b0)
      $display("FAIL t5_rst_ctl: got %b want 00000",
               {a_s[0], b_s[0], busy_s[0], done_s[0], pass_s[0]});
    else n_pass++;
    n_total++;
    if ({err_s[0], ffv[0], ffm[0]} !== 17'b0)
      $display("FAIL t5_rst_regs: got %h want 0", {err_s[0], ffv[0], ffm[0]});
    else n_pass++;
    edges(2);
    rst_n = 1'b1;
    stk0[0] = 7'b0;
    edges(6);
    n_total++;
    if ({busy_s[0], done_s[0], b_s[0], a_s[0]} !== 4'b0)
      $display("FAIL t5_idle: got %b want 0000", {busy_s[0], done_s[0], b_s[0], a_s[0]});
    else n_pass++;
    start_pulse(0);
    edges(16);
    n_total++;
    if ({done_s[0], pass_s[0], err_s[0]} !== {2'b11, 8'd0})
      $display("FAIL t5_rerun: got %h want 300", {done_s[0], pass_s[0], err_s[0]});
    else n_pass++;
  endtask

  task automatic test_settle();
    start_pulse(3);
    edges(11);
    n_total++;
    if (done_s[3] !== 1'b0) $display("FAIL t6_s1_early: got %b want 0", done_s[3]);
    else n_pass++;
    edges(1);
    n_total++;
    if ({done_s[3], pass_s[3]} !== 2'b11)
      $display("FAIL t6_s1_done12: got %b want 11", {done_s[3], pass_s[3]});
    else n_pass++;
    start_pulse(4);
    edges(2);
    flip[4] = 7'h7f;
    edges(2);
    flip[4] = 7'h00;
    edges(23);
    n_total++;
    if (done_s[4] !== 1'b0) $display("FAIL t6_s5_early: got %b want 0", done_s[4]);
    else n_pass++;
    edges(1);
    n_total++;
    if ({done_s[4], pass_s[4]} !== 2'b11)
      $display("FAIL t6_s5_done28: got %b want 11", {done_s[4], pass_s[4]});
    else n_pass++;
    n_total++;
    if (err_s[4] !== 8'd0) $display("FAIL t6_glitch: got %0d want 0", err_s[4]);
    else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      start[i] = 1'b0;
      flip[i]  = '0;
      stk1[i]  = '0;
      stk0[i]  = '0;
    end
    edges(3);
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    edges(2);
    test_clean_run();
    test_xor_fault();
    test_passes_saturation();
    test_back_to_back();
    test_async_reset();
    test_settle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
